// File: rtl/slot_pkg.sv
// Shared constants, reel state encoding and target reduction helper for the reel animator.
package slot_pkg;

  localparam int unsigned NUM_REELS = 3;
  localparam int unsigned SYM_W     = 3;
  localparam int unsigned CORDW     = 16;
  localparam int unsigned Y_HOME    = 176;

  // Galois LFSR x^16 + x^14 + x^13 + x^11, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, SPIN, STOPPING} reel_state_t;

  // Fold a raw 3-bit field into 0..num_sym-1 (single subtract suffices for num_sym >= 4)
  function automatic logic [SYM_W-1:0] reduce_sym(input logic [SYM_W-1:0] raw,
                                                  input int unsigned     num_sym);
    reduce_sym = (32'(raw) >= num_sym) ? SYM_W'(32'(raw) - num_sym) : raw;
  endfunction

endpackage

// File: rtl/reel_channel.sv
// One reel: scroll position, current symbol, spin countdown and landing target.
module reel_channel
  import slot_pkg::*;
#(
  parameter int unsigned NUM_SYM = 6,
  parameter int unsigned SPEED   = 8,
  parameter int unsigned SYM_H   = 128,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [SYM_W-1:0]  target_in,
  input  logic [CNT_W-1:0]  cnt_init,
  output logic [CORDW-1:0]  y,
  output logic [SYM_W-1:0]  sym,
  output logic              stopped,
  output logic              land_c
);

  localparam logic [CORDW-1:0] Y_HOME_V = CORDW'(Y_HOME);
  localparam logic [CORDW-1:0] Y_WRAP   = CORDW'(Y_HOME + SYM_H);

  reel_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [SYM_W-1:0] target;
  logic [CORDW-1:0] y_adv;
  logic [SYM_W-1:0] sym_adv;
  logic             at_target;

  // One-tick advance with sprite wrap and symbol increment
  always_comb begin
    y_adv   = y + CORDW'(SPEED);
    sym_adv = sym;
    if (y_adv >= Y_WRAP) begin
      y_adv   = y_adv - CORDW'(SYM_H);
      sym_adv = (sym == SYM_W'(NUM_SYM - 1)) ? '0 : sym + SYM_W'(1);
    end
  end

  assign at_target = (y == Y_HOME_V) && (sym == target);
  assign land_c    = tick && (state == STOPPING) && at_target;
  assign stopped   = (state == IDLE);

  // Reel FSM; an accepted start overrides a coincident tick
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      y      <= Y_HOME_V;
      sym    <= '0;
      cnt    <= '0;
      target <= '0;
    end else if (start) begin
      state  <= SPIN;
      cnt    <= cnt_init;
      target <= target_in;
    end else if (tick) begin
      case (state)
        IDLE: y <= Y_HOME_V;
        SPIN: begin
          y   <= y_adv;
          sym <= sym_adv;
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= STOPPING;
        end
        STOPPING: begin
          if (at_target) begin
            state <= IDLE;
          end else begin
            y   <= y_adv;
            sym <= sym_adv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reel_spin_ctrl.sv
// Three-reel slot animator: tick divider, LFSR, start accept, completion and bus packing.
// Optional build macro REEL_FORCE_EN adds force_en/force_syms to override the landing targets.
module reel_spin_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 1_666_667,
  parameter int unsigned NUM_SYM        = 6,
  parameter int unsigned SPEED          = 8,
  parameter int unsigned SYM_H          = 128,
  parameter int unsigned MIN_SPIN_TICKS = 90,
  parameter int unsigned STAGGER_TICKS  = 30
) (
  input  logic                         clk_100,
  input  logic                         rst,
  input  logic                         spin_start,
`ifdef REEL_FORCE_EN
  input  logic                         force_en,
  input  logic [NUM_REELS*SYM_W-1:0]   force_syms,
`endif
  output logic [NUM_REELS*SYM_W-1:0]   symbols,
  output logic [NUM_REELS*CORDW-1:0]   symbols_y_coords,
  output logic                         symbols_valid,
  output logic                         busy,
  output logic                         spin_done,
  output logic                         win
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = 16;

  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic [15:0]          lfsr;
  logic                 start_acc;
  logic                 done_c;
  logic [NUM_REELS-1:0] stopped;
  logic [NUM_REELS-1:0] land_c;
  logic [SYM_W-1:0]     sym_r [NUM_REELS];
  logic [CORDW-1:0]     y_r   [NUM_REELS];
  logic [NUM_REELS*SYM_W-1:0] target_src;

  assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign start_acc = spin_start && !busy;
  assign done_c    = busy && tick && (&(stopped | land_c));

`ifdef REEL_FORCE_EN
  assign target_src = force_en ? force_syms : lfsr[NUM_REELS*SYM_W-1:0];
`else
  assign target_src = lfsr[NUM_REELS*SYM_W-1:0];
`endif

  // Tick divider, LFSR, strobe and spin bookkeeping
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      tick_cnt      <= '0;
      lfsr          <= LFSR_SEED;
      symbols_valid <= 1'b0;
      busy          <= 1'b0;
      spin_done     <= 1'b0;
      win           <= 1'b0;
    end else begin
      tick_cnt      <= tick ? '0 : tick_cnt + TICK_W'(1);
      lfsr          <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      symbols_valid <= tick;
      spin_done     <= done_c;
      if (start_acc) begin
        busy <= 1'b1;
        win  <= 1'b0;
      end else if (done_c) begin
        busy <= 1'b0;
        win  <= (sym_r[0] == sym_r[1]) && (sym_r[1] == sym_r[2]);
      end
    end
  end

  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    reel_channel #(
      .NUM_SYM (NUM_SYM),
      .SPEED   (SPEED),
      .SYM_H   (SYM_H),
      .CNT_W   (CNT_W)
    ) u_reel (
      .clk_100   (clk_100),
      .rst       (rst),
      .tick      (tick),
      .start     (start_acc),
      .target_in (reduce_sym(target_src[SYM_W*i +: SYM_W], NUM_SYM)),
      .cnt_init  (CNT_W'(MIN_SPIN_TICKS + i * STAGGER_TICKS)),
      .y         (y_r[i]),
      .sym       (sym_r[i]),
      .stopped   (stopped[i]),
      .land_c    (land_c[i])
    );

    assign symbols[SYM_W*i +: SYM_W]          = sym_r[i];
    assign symbols_y_coords[CORDW*i +: CORDW] = y_r[i];
  end

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Self-checking bench for reel_spin_ctrl with a closed-form reel position model.
module tb_reel_spin_ctrl;

  localparam int unsigned TICK_DIV = 20;
  localparam int unsigned NUM_SYM  = 6;
  localparam int unsigned SPEED    = 8;
  localparam int unsigned SYM_H    = 128;
  localparam int unsigned MIN_SPIN = 4;
  localparam int unsigned STAGGER  = 8;
  localparam int unsigned Y_HOME   = 176;
  localparam int unsigned LOOP_LEN = NUM_SYM * SYM_H;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic        spin_start = 1'b0;
`ifdef REEL_FORCE_EN
  logic        force_en = 1'b0;
  logic [8:0]  force_syms = 9'd0;
`endif
  logic [8:0]  symbols;
  logic [47:0] symbols_y_coords;
  logic        symbols_valid, busy, spin_done, win;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_sym [3];
  logic [15:0] m_lfsr;

  always #5 clk_100 = ~clk_100;

  reel_spin_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .NUM_SYM        (NUM_SYM),
    .SPEED          (SPEED),
    .SYM_H          (SYM_H),
    .MIN_SPIN_TICKS (MIN_SPIN),
    .STAGGER_TICKS  (STAGGER)
  ) dut (
    .clk_100          (clk_100),
    .rst              (rst),
    .spin_start       (spin_start),
`ifdef REEL_FORCE_EN
    .force_en         (force_en),
    .force_syms       (force_syms),
`endif
    .symbols          (symbols),
    .symbols_y_coords (symbols_y_coords),
    .symbols_valid    (symbols_valid),
    .busy             (busy),
    .spin_done        (spin_done),
    .win              (win)
  );

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11, one step per clock
  always @(posedge clk_100 or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bus after n ticks: each reel has covered SPEED*min(n, moving ticks) pixels of its loop
  task automatic chk_bus(input int n, input int ps[3], input int mv[3]);
    logic [8:0]  es;
    logic [47:0] ey;
    int steps, p;
    for (int i = 0; i < 3; i++) begin
      steps = (n < mv[i]) ? n : mv[i];
      p = (ps[i] + SPEED * steps) % LOOP_LEN;
      es[3*i +: 3]   = 3'(p / SYM_H);
      ey[16*i +: 16] = 16'(Y_HOME + p % SYM_H);
    end
    chk($sformatf("symbols_t%0d", n), 64'(symbols), 64'(es));
    chk($sformatf("ycoords_t%0d", n), 64'(symbols_y_coords), 64'(ey));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_symbols"}, 64'(symbols), 64'(0));
    chk({tag, "_ycoords"}, 64'(symbols_y_coords), {16'd0, 16'd176, 16'd176, 16'd176});
    chk({tag, "_valid"}, 64'(symbols_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(spin_done), 64'(0));
    chk({tag, "_win"}, 64'(win), 64'(0));
  endtask

  // Start a spin at the current negedge and follow it tick by tick; abort_after>0 stops following early
  task automatic run_spin(input bit use_force, input logic [8:0] fs, input bit poke,
                          input int abort_after, output bit exp_win);
    logic [8:0] src;
    int tgt[3], ps[3], mv[3], c, k, ndone, n, budget;
    bit poked;
`ifdef REEL_FORCE_EN
    src = use_force ? fs : m_lfsr[8:0];
    force_en = use_force;
    force_syms = fs;
`else
    src = m_lfsr[8:0];
`endif
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tgt[i] = int'(src[3*i +: 3]);
      if (tgt[i] >= NUM_SYM) tgt[i] -= NUM_SYM;
      ps[i] = cur_sym[i] * SYM_H;
      c = MIN_SPIN + i * STAGGER;
      k = 0;
      while (((ps[i] + (c + k) * SPEED) % LOOP_LEN) != tgt[i] * SYM_H) k++;
      mv[i] = c + k;
      if (c + k + 1 > ndone) ndone = c + k + 1;
    end
    exp_win = (tgt[0] == tgt[1]) && (tgt[1] == tgt[2]);
    spin_start = 1'b1;
    @(negedge clk_100);
    spin_start = 1'b0;
`ifdef REEL_FORCE_EN
    force_en = 1'b0;
`endif
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("win_cleared_on_start", 64'(win), 64'(0));
    n = 0;
    if (symbols_valid) chk_bus(0, ps, mv);
    poked = 1'b0;
    budget = (ndone + 3) * TICK_DIV;
    while (n < ndone && budget > 0 && !(abort_after > 0 && n >= abort_after)) begin
      spin_start = 1'b0;
      if (poke && !poked && n == 2) begin
        spin_start = 1'b1;
        poked = 1'b1;
`ifdef REEL_FORCE_EN
        force_en = 1'b1;
        force_syms = 9'($urandom);
`endif
      end
      @(negedge clk_100);
      budget--;
      if (symbols_valid) begin
        n++;
        chk_bus(n, ps, mv);
        chk($sformatf("spin_done_t%0d", n), 64'(spin_done), 64'(n == ndone));
        chk($sformatf("busy_t%0d", n), 64'(busy), 64'(n < ndone));
      end else if (spin_done !== 1'b0) begin
        chk("spin_done_off_tick", 64'(spin_done), 64'(0));
      end
    end
    spin_start = 1'b0;
`ifdef REEL_FORCE_EN
    force_en = 1'b0;
`endif
    if (abort_after > 0) return;
    chk("spin_completed_ticks", 64'(n), 64'(ndone));
    chk("win_at_done", 64'(win), 64'(exp_win));
    for (int i = 0; i < 3; i++) cur_sym[i] = tgt[i];
    // exactly one done pulse, win held through idle ticks
    for (int j = 0; j < 2 * TICK_DIV + 5; j++) begin
      @(negedge clk_100);
      if (spin_done !== 1'b0 || busy !== 1'b0 || win !== exp_win) begin
        chk("post_done_spin_done", 64'(spin_done), 64'(0));
        chk("post_done_busy", 64'(busy), 64'(0));
        chk("post_done_win_hold", 64'(win), 64'(exp_win));
      end
    end
    chk("idle_win_held", 64'(win), 64'(exp_win));
  endtask

  initial begin
    bit   ew;
    int   first_idx, last, per_ok, seen_done;
    logic [8:0] rs;

    for (int i = 0; i < 3; i++) cur_sym[i] = 0;

    // 1. reset values, then idle strobe cadence
    #23;
    chk_idle_outputs("reset");
    @(negedge clk_100);
    rst = 1'b0;
    first_idx = 0;
    for (int j = 1; j <= 30 && first_idx == 0; j++) begin
      @(negedge clk_100);
      if (symbols_valid) first_idx = j;
    end
    chk("first_strobe_latency_ok", 64'(first_idx == 20 || first_idx == 21), 64'(1));
    last = 0;
    per_ok = 1;
    for (int j = 1; j <= 180; j++) begin
      @(negedge clk_100);
      if (symbols_valid) begin
        if (j - last != TICK_DIV) per_ok = 0;
        last = j;
      end
    end
    chk("idle_strobe_period", 64'(per_ok), 64'(1));
    chk("idle_symbols", 64'(symbols), 64'(0));
    chk("idle_ycoords", 64'(symbols_y_coords), {16'd0, 16'd176, 16'd176, 16'd176});
    chk("idle_busy", 64'(busy), 64'(0));

    // 2. forced {1,5,2}
    run_spin(1'b1, {3'd1, 3'd5, 3'd2}, 1'b0, 0, ew);
`ifdef REEL_FORCE_EN
    chk("force_152_symbols", 64'(symbols), 64'(9'b001_101_010));
    chk("force_152_win", 64'(win), 64'(0));
`endif

    // 3. forced {4,4,4}
    run_spin(1'b1, {3'd4, 3'd4, 3'd4}, 1'b0, 0, ew);

    // 6. forced {0,0,7}: reel2 target folds to 1; also start exactly on a tick, and a busy poke (4)
    for (int j = 0; j < 3 * TICK_DIV && !symbols_valid; j++) @(negedge clk_100);
    for (int j = 0; j < TICK_DIV - 1; j++) @(negedge clk_100);
    run_spin(1'b1, {3'd7, 3'd0, 3'd0}, 1'b1, 0, ew);

    // randomized spins, random phase, LFSR or forced targets
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < int'($urandom_range(0, 25)); j++) @(negedge clk_100);
      rs = 9'($urandom);
      run_spin(1'($urandom), rs, 1'($urandom), 0, ew);
    end

    // 5. reset mid-spin
    run_spin(1'b0, 9'd0, 1'b0, 6, ew);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_spin_reset");
    @(negedge clk_100);
    @(negedge clk_100);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cur_sym[i] = 0;
    seen_done = 0;
    for (int j = 0; j < 3 * TICK_DIV; j++) begin
      @(negedge clk_100);
      if (spin_done) seen_done++;
    end
    chk("no_done_after_reset", 64'(seen_done), 64'(0));
    run_spin(1'b0, 9'd0, 1'b0, 0, ew);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
